// File: rtl/axi_lite_master_basic.sv
// axi_lite_master_basic
// ---------------------------------------------------------------------------
// Single-outstanding AXI-Lite initiator. A local command (write or read of one
// DATA_W-bit word) is turned into the AXI-Lite AW/W/B or AR/R handshakes, and
// exactly one rsp_valid pulse is returned per command. The pulse carries the
// read data, the response code and the transaction latency in cycles.
//
// Ports:
//   ACLK, ARESET          clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (accepted when both high at an edge)
//   cmd_write             1 = write, 0 = read
//   cmd_addr, cmd_wdata   byte address and write data
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata             read data (0 for writes)
//   rsp_resp              BRESP/RRESP of the completed transaction
//   rsp_cycles            saturating latency, held until the next completion
//   M_AW*, M_W*, M_B*     AXI-Lite write channels
//   M_AR*, M_R*           AXI-Lite read channels
// ---------------------------------------------------------------------------
module axi_lite_master_basic #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [CNT_W-1:0]      rsp_cycles,
  output logic [ADDR_W-1:0]     M_AWADDR,
  output logic                  M_AWVALID,
  input  logic                  M_AWREADY,
  output logic [DATA_W-1:0]     M_WDATA,
  output logic [DATA_W/8-1:0]   M_WSTRB,
  output logic                  M_WVALID,
  input  logic                  M_WREADY,
  input  logic [1:0]            M_BRESP,
  input  logic                  M_BVALID,
  output logic                  M_BREADY,
  output logic [ADDR_W-1:0]     M_ARADDR,
  output logic                  M_ARVALID,
  input  logic                  M_ARREADY,
  input  logic [DATA_W-1:0]     M_RDATA,
  input  logic [1:0]            M_RRESP,
  input  logic                  M_RVALID,
  output logic                  M_RREADY
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    WRESP = 2'd2,
    READ  = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;

  logic accept_s;
  logic aw_done_s;
  logic w_done_s;
  logic b_hs_s;
  logic r_hs_s;
  logic cnt_max_s;

  // Idle and not held in reset; drops combinationally while ARESET is high.
  assign cmd_ready = (state_r == IDLE) && !ARESET;
  assign accept_s  = cmd_valid && cmd_ready;

  // A channel counts as done once its VALID has dropped or is being taken now.
  assign aw_done_s = !M_AWVALID || M_AWREADY;
  assign w_done_s  = !M_WVALID  || M_WREADY;
  assign b_hs_s    = M_BVALID && M_BREADY;
  // R is only taken once AR has completed (or completes on this same edge).
  assign r_hs_s    = M_RVALID && M_RREADY && (!M_ARVALID || M_ARREADY);

  assign cnt_max_s = (cnt_r == {CNT_W{1'b1}});

  // Full-byte writes only.
  assign M_WSTRB = {(DATA_W/8){1'b1}};

  // State register.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = cmd_write ? WRITE : READ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITE: begin
        if (aw_done_s && w_done_s) begin
          state_nxt_s = WRESP;
        end else begin
          state_nxt_s = WRITE;
        end
      end
      WRESP: begin
        if (b_hs_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WRESP;
        end
      end
      READ: begin
        if (r_hs_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = READ;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Registered AXI channel controls, payloads, latency counter and response.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      M_AWADDR   <= {ADDR_W{1'b0}};
      M_AWVALID  <= 1'b0;
      M_WDATA    <= {DATA_W{1'b0}};
      M_WVALID   <= 1'b0;
      M_BREADY   <= 1'b0;
      M_ARADDR   <= {ADDR_W{1'b0}};
      M_ARVALID  <= 1'b0;
      M_RREADY   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= {DATA_W{1'b0}};
      rsp_resp   <= 2'b00;
      rsp_cycles <= {CNT_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
    end else begin
      rsp_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            // First VALID cycle counts as cycle 1.
            cnt_r <= {{(CNT_W-1){1'b0}}, 1'b1};
            if (cmd_write) begin
              M_AWADDR  <= cmd_addr;
              M_WDATA   <= cmd_wdata;
              M_AWVALID <= 1'b1;
              M_WVALID  <= 1'b1;
            end else begin
              M_ARADDR  <= cmd_addr;
              M_ARVALID <= 1'b1;
              M_RREADY  <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (!cnt_max_s) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
          if (M_AWVALID && M_AWREADY) begin
            M_AWVALID <= 1'b0;
          end
          if (M_WVALID && M_WREADY) begin
            M_WVALID <= 1'b0;
          end
          if (aw_done_s && w_done_s) begin
            M_BREADY <= 1'b1;
          end
        end
        WRESP: begin
          if (!cnt_max_s) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
          if (b_hs_s) begin
            M_BREADY   <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_resp   <= M_BRESP;
            rsp_rdata  <= {DATA_W{1'b0}};
            rsp_cycles <= cnt_r;
          end
        end
        READ: begin
          if (!cnt_max_s) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
          if (M_ARVALID && M_ARREADY) begin
            M_ARVALID <= 1'b0;
          end
          if (r_hs_s) begin
            M_RREADY   <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_resp   <= M_RRESP;
            rsp_rdata  <= M_RDATA;
            rsp_cycles <= cnt_r;
          end
        end
        default: begin
          M_AWVALID <= 1'b0;
          M_WVALID  <= 1'b0;
          M_BREADY  <= 1'b0;
          M_ARVALID <= 1'b0;
          M_RREADY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_master_basic.sv
// Directed testbench for axi_lite_master_basic. The bench plays the slave
// cycle by cycle; inputs are driven and outputs checked 1 ns after each
// rising edge.
module tb_axi_lite_master_basic;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  logic                ACLK;
  logic                ARESET;
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_write;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;
  logic                rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;
  logic [1:0]          rsp_resp;
  logic [CNT_W-1:0]    rsp_cycles;
  logic [ADDR_W-1:0]   M_AWADDR;
  logic                M_AWVALID;
  logic                M_AWREADY;
  logic [DATA_W-1:0]   M_WDATA;
  logic [DATA_W/8-1:0] M_WSTRB;
  logic                M_WVALID;
  logic                M_WREADY;
  logic [1:0]          M_BRESP;
  logic                M_BVALID;
  logic                M_BREADY;
  logic [ADDR_W-1:0]   M_ARADDR;
  logic                M_ARVALID;
  logic                M_ARREADY;
  logic [DATA_W-1:0]   M_RDATA;
  logic [1:0]          M_RRESP;
  logic                M_RVALID;
  logic                M_RREADY;

  int checks = 0;
  int errors = 0;

  axi_lite_master_basic #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_cycles(rsp_cycles),
    .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic slave_idle();
    M_AWREADY = 1'b0; M_WREADY = 1'b0; M_BVALID = 1'b0; M_BRESP = 2'b00;
    M_ARREADY = 1'b0; M_RVALID = 1'b0; M_RRESP = 2'b00; M_RDATA = 32'h0;
  endtask

  // Present one command for exactly one (accepting) edge.
  task automatic issue(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    ARESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 4'h0; cmd_wdata = 32'h0;
    slave_idle();
    #1;
    checks++;
    if ({M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, rsp_valid} !== 6'b000000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000000",
        {M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY, rsp_valid});
    end
    checks++;
    if ({M_AWADDR, M_ARADDR, M_WDATA, rsp_rdata, rsp_resp, rsp_cycles} !== 82'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 0",
        {M_AWADDR, M_ARADDR, M_WDATA, rsp_rdata, rsp_resp, rsp_cycles});
    end
    checks++;
    if (M_WSTRB !== 4'hF) begin errors++; $display("FAIL reset_wstrb: got %h expected f", M_WSTRB); end
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready_in_reset: got %b expected 0", cmd_ready); end
    tick(); tick();
    ARESET = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready_after: got %b expected 1", cmd_ready); end
    tick();
  endtask

  task automatic test_write_basic();
    issue(1'b1, 4'h4, 32'hDEADBEEF);
    checks++;
    if ({M_AWVALID, M_WVALID, M_BREADY, cmd_ready} !== 4'b1100) begin
      errors++; $display("FAIL wr_c1_ctrl: got %b expected 1100", {M_AWVALID, M_WVALID, M_BREADY, cmd_ready});
    end
    checks++;
    if (M_AWADDR !== 4'h4 || M_WDATA !== 32'hDEADBEEF || M_WSTRB !== 4'hF) begin
      errors++; $display("FAIL wr_c1_payload: got %h %h %h expected 4 deadbeef f", M_AWADDR, M_WDATA, M_WSTRB);
    end
    M_AWREADY = 1'b1; M_WREADY = 1'b1;
    tick();
    checks++;
    if ({M_AWVALID, M_WVALID, M_BREADY} !== 3'b001) begin
      errors++; $display("FAIL wr_c2_ctrl: got %b expected 001", {M_AWVALID, M_WVALID, M_BREADY});
    end
    M_AWREADY = 1'b0; M_WREADY = 1'b0; M_BVALID = 1'b1; M_BRESP = 2'b00;
    tick();
    M_BVALID = 1'b0;
    checks++;
    if ({rsp_valid, M_BREADY, cmd_ready} !== 3'b101 || rsp_resp !== 2'b00 ||
        rsp_rdata !== 32'h0 || rsp_cycles !== 8'd2) begin
      errors++; $display("FAIL wr_rsp: got v/bready/rdy=%b resp=%b rdata=%h cyc=%0d expected 101 00 0 2",
        {rsp_valid, M_BREADY, cmd_ready}, rsp_resp, rsp_rdata, rsp_cycles);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_rsp_pulse: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_read_basic();
    issue(1'b0, 4'h4, 32'h0);
    checks++;
    if ({M_ARVALID, M_RREADY, M_AWVALID} !== 3'b110 || M_ARADDR !== 4'h4) begin
      errors++; $display("FAIL rd_c1: got %b addr=%h expected 110 4", {M_ARVALID, M_RREADY, M_AWVALID}, M_ARADDR);
    end
    M_ARREADY = 1'b1; M_RVALID = 1'b1; M_RDATA = 32'hDEADBEEF; M_RRESP = 2'b00;
    tick();
    slave_idle();
    checks++;
    if ({rsp_valid, M_ARVALID, M_RREADY} !== 3'b100 || rsp_rdata !== 32'hDEADBEEF ||
        rsp_resp !== 2'b00 || rsp_cycles !== 8'd1) begin
      errors++; $display("FAIL rd_rsp: got %b rdata=%h resp=%b cyc=%0d expected 100 deadbeef 00 1",
        {rsp_valid, M_ARVALID, M_RREADY}, rsp_rdata, rsp_resp, rsp_cycles);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_cycles !== 8'd1) begin
      errors++; $display("FAIL rd_hold: got v=%b cyc=%0d expected 0 1", rsp_valid, rsp_cycles);
    end
  endtask

  task automatic test_write_skewed();
    issue(1'b1, 4'h8, 32'h0BADCAFE);
    checks++;
    if ({M_AWVALID, M_WVALID} !== 2'b11) begin
      errors++; $display("FAIL sk_c1: got %b expected 11", {M_AWVALID, M_WVALID});
    end
    M_WREADY = 1'b1;
    tick();
    M_WREADY = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      checks++;
      if ({M_AWVALID, M_WVALID, M_BREADY} !== 3'b100 || M_AWADDR !== 4'h8) begin
        errors++; $display("FAIL sk_hold_c%0d: got %b addr=%h expected 100 8", k,
          {M_AWVALID, M_WVALID, M_BREADY}, M_AWADDR);
      end
      if (k == 4) M_AWREADY = 1'b1;
      tick();
    end
    M_AWREADY = 1'b0;
    checks++;
    if ({M_AWVALID, M_BREADY} !== 2'b01) begin
      errors++; $display("FAIL sk_c5: got %b expected 01", {M_AWVALID, M_BREADY});
    end
    M_BVALID = 1'b1; M_BRESP = 2'b10;
    tick();
    slave_idle();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_resp !== 2'b10 || rsp_rdata !== 32'h0 || rsp_cycles !== 8'd5) begin
      errors++; $display("FAIL sk_rsp: got v=%b resp=%b rdata=%h cyc=%0d expected 1 10 0 5",
        rsp_valid, rsp_resp, rsp_rdata, rsp_cycles);
    end
    tick();
  endtask

  task automatic test_read_error();
    issue(1'b0, 4'hC, 32'h0);
    // RVALID before AR completes must be ignored.
    M_RVALID = 1'b1; M_RDATA = 32'h12345678; M_RRESP = 2'b11;
    tick();
    checks++;
    if ({rsp_valid, M_ARVALID, M_RREADY} !== 3'b011) begin
      errors++; $display("FAIL rde_early_r: got %b expected 011", {rsp_valid, M_ARVALID, M_RREADY});
    end
    M_ARREADY = 1'b1;
    tick();
    slave_idle();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_resp !== 2'b11 || rsp_rdata !== 32'h12345678 || rsp_cycles !== 8'd2) begin
      errors++; $display("FAIL rde_rsp: got v=%b resp=%b rdata=%h cyc=%0d expected 1 11 12345678 2",
        rsp_valid, rsp_resp, rsp_rdata, rsp_cycles);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h0; cmd_wdata = 32'h11112222;
    tick();
    cmd_write = 1'b0; cmd_addr = 4'h8;  // second command held during the write
    checks++;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_busy_ready: got %b expected 0", cmd_ready); end
    M_AWREADY = 1'b1; M_WREADY = 1'b1;
    tick();
    M_AWREADY = 1'b0; M_WREADY = 1'b0; M_BVALID = 1'b1;
    checks++;
    if ({M_ARVALID, cmd_ready} !== 2'b00) begin
      errors++; $display("FAIL b2b_ignored: got %b expected 00", {M_ARVALID, cmd_ready});
    end
    tick();
    M_BVALID = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready, M_ARVALID} !== 3'b110) begin
      errors++; $display("FAIL b2b_rsp_cycle: got %b expected 110", {rsp_valid, cmd_ready, M_ARVALID});
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if ({M_ARVALID, M_RREADY, rsp_valid} !== 3'b110 || M_ARADDR !== 4'h8) begin
      errors++; $display("FAIL b2b_read_start: got %b addr=%h expected 110 8",
        {M_ARVALID, M_RREADY, rsp_valid}, M_ARADDR);
    end
    M_ARREADY = 1'b1; M_RVALID = 1'b1; M_RDATA = 32'hCAFE0001;
    tick();
    slave_idle();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFE0001 || rsp_cycles !== 8'd1) begin
      errors++; $display("FAIL b2b_read_rsp: got v=%b rdata=%h cyc=%0d expected 1 cafe0001 1",
        rsp_valid, rsp_rdata, rsp_cycles);
    end
    tick();
  endtask

  task automatic test_reset_mid_read();
    issue(1'b0, 4'h4, 32'h0);
    checks++;
    if (M_ARVALID !== 1'b1) begin errors++; $display("FAIL mr_start: got %b expected 1", M_ARVALID); end
    #2 ARESET = 1'b1;
    #1;
    checks++;
    if ({M_ARVALID, M_RREADY, cmd_ready, rsp_valid} !== 4'b0000) begin
      errors++; $display("FAIL mr_async: got %b expected 0000", {M_ARVALID, M_RREADY, cmd_ready, rsp_valid});
    end
    tick();
    ARESET = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, rsp_valid, M_ARVALID} !== 3'b100 || rsp_cycles !== 8'd0) begin
      errors++; $display("FAIL mr_release: got %b cyc=%0d expected 100 0",
        {cmd_ready, rsp_valid, M_ARVALID}, rsp_cycles);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mr_no_rsp_%0d: got %b expected 0", k, rsp_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_basic();
    test_write_skewed();
    test_read_error();
    test_back_to_back();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
